// File: rtl/ipsxe_floating_point_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ipsxe_floating_point_pkg
// Purpose : Shared definitions for the iterative floating-point blocks.
//           Holds the FSM state encoding and helpers that derive the
//           exponent bias and the all-ones exponent code from the exponent
//           field width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ipsxe_floating_point_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // IEEE-754 exponent bias: 2^(E-1) - 1
  function automatic int f_bias(input int exp_size);
    return (1 << (exp_size - 1)) - 1;
  endfunction

  // Reserved exponent code for Inf/NaN: 2^E - 1
  function automatic int f_exp_ones(input int exp_size);
    return (1 << exp_size) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipsxe_floating_point_square_round_v1_0.sv
`default_nettype none
// ============================================================================
// Module  : ipsxe_floating_point_square_round_v1_0
// Purpose : Combinational back end of the squarer. Normalises the raw
//           mantissa product, rounds to nearest-even, detects exponent
//           overflow/underflow and substitutes the special-case results.
// Ports   : i_sign      - result sign (x*x, always 0)
//           i_exp/i_man - operand fields (denormals already flushed)
//           i_prod      - {1,man}*{1,man}, 2*(MANTISSA_SIZE+1) bits
//           o_result    - packed IEEE-754 result
//           o_overflow  - finite input saturated to +Inf
//           o_underflow - nonzero finite input flushed to +0
// Revision: 1.0 - initial release
// ============================================================================
module ipsxe_floating_point_square_round_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23
) (
  input  logic                                 i_sign,
  input  logic [EXPONENT_SIZE-1:0]             i_exp,
  input  logic [MANTISSA_SIZE-1:0]             i_man,
  input  logic [2*MANTISSA_SIZE+1:0]           i_prod,
  output logic [EXPONENT_SIZE+MANTISSA_SIZE:0] o_result,
  output logic                                 o_overflow,
  output logic                                 o_underflow
);

  localparam int E = EXPONENT_SIZE;
  localparam int M = MANTISSA_SIZE;
  localparam int P = 2 * (M + 1);
  localparam int C_BIAS_I = f_bias(E);
  localparam int C_ONES_I = f_exp_ones(E);
  localparam logic [E+1:0] C_BIAS = C_BIAS_I[E+1:0];
  localparam logic [E+1:0] C_ONES = C_ONES_I[E+1:0];

  logic         w_norm;
  logic [P-1:0] w_shift;
  logic [M-1:0] w_mant;
  logic         w_guard;
  logic         w_sticky;
  logic         w_up;
  logic [M:0]   w_mant_r;
  logic         w_carry;
  logic [E+1:0] w_exp;
  logic         w_ovf;
  logic         w_unf;

  // Product of two [1,2) values lies in [1,4); when the top bit is set the
  // value is >= 2 and the exponent gains one. Left-aligning the other case
  // puts the hidden one at P-1 for both, and keeps every discarded bit
  // inside the sticky field.
  assign w_norm   = i_prod[P-1];
  assign w_shift  = w_norm ? i_prod : {i_prod[P-2:0], 1'b0};
  assign w_mant   = w_shift[P-2 -: M];
  assign w_guard  = w_shift[P-2-M];
  assign w_sticky = |w_shift[P-3-M:0];

  // Round up above half, or exactly half with an odd LSB.
  assign w_up     = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_r = {1'b0, w_mant} + {{M{1'b0}}, w_up};
  // A carry out only happens from all-ones, so the low bits are already 0.
  assign w_carry  = w_mant_r[M];

  // Signed E+2 bits: 2*e - BIAS + norm + carry
  assign w_exp = {1'b0, i_exp, 1'b0} - C_BIAS
               + {{(E+1){1'b0}}, w_norm} + {{(E+1){1'b0}}, w_carry};
  assign w_ovf = !w_exp[E+1] && (w_exp >= C_ONES);
  assign w_unf = w_exp[E+1] || (w_exp == '0);

  always_comb begin
    o_result    = '0;
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    if (i_exp == {E{1'b1}}) begin
      if (i_man != '0)
        o_result = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      else
        o_result = {1'b0, {E{1'b1}}, {M{1'b0}}};
    end else if (i_exp == '0) begin
      o_result = '0;
    end else if (w_ovf) begin
      o_result   = {i_sign, {E{1'b1}}, {M{1'b0}}};
      o_overflow = 1'b1;
    end else if (w_unf) begin
      o_result    = {i_sign, {(E+M){1'b0}}};
      o_underflow = 1'b1;
    end else begin
      o_result = {i_sign, w_exp[E-1:0], w_mant_r[M-1:0]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ipsxe_floating_point_square_v1_0.sv
`default_nettype none
// ============================================================================
// Module  : ipsxe_floating_point_square_v1_0
// Purpose : Iterative IEEE-754 squarer (x*x). One multiplier bit is consumed
//           per enabled cycle by a shift-add datapath; the result is rounded
//           to nearest-even. Fixed latency of MANTISSA_SIZE+3 enabled cycles.
// Ports   : i_clk, i_rst_n (sync, active-low), i_aclken (clock enable)
//           i_valid/i_fp    - operand handshake, accepted when o_ready=1
//           o_ready         - idle, can accept an operand
//           o_valid         - one-enabled-cycle pulse qualifying outputs
//           o_result        - x*x
//           o_overflow      - finite input saturated to +Inf
//           o_underflow     - nonzero finite input flushed to +0
// Revision: 1.0 - initial release
// ============================================================================
module ipsxe_floating_point_square_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_aclken,
  input  logic                                 i_valid,
  input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] i_fp,
  output logic                                 o_ready,
  output logic [EXPONENT_SIZE+MANTISSA_SIZE:0] o_result,
  output logic                                 o_valid,
  output logic                                 o_overflow,
  output logic                                 o_underflow
);

  localparam int E     = EXPONENT_SIZE;
  localparam int M     = MANTISSA_SIZE;
  localparam int FW    = 1 + E + M;
  localparam int MW    = M + 1;
  localparam int PW    = 2 * MW;
  localparam int CNT_W = $clog2(MANTISSA_SIZE + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MANTISSA_SIZE);

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_sign;
  logic [E-1:0]    r_exp;
  logic [M-1:0]    r_man;
  logic [PW-1:0]   r_mcand;
  logic [MW-1:0]   r_mplr;
  logic [PW-1:0]   r_acc;
  logic [FW-1:0]   r_rnd_result;
  logic            r_rnd_ovf;
  logic            r_rnd_unf;
  logic            r_ready;
  logic            r_valid;
  logic [FW-1:0]   r_result;
  logic            r_ovf;
  logic            r_unf;

  logic [E-1:0]    w_in_exp;
  logic [M-1:0]    w_in_man;
  logic            w_sign;
  logic [FW-1:0]   w_result;
  logic            w_ovf;
  logic            w_unf;

  // Denormals are flushed to zero: exponent 0 forces a zero mantissa.
  assign w_in_exp = i_fp[E+M-1:M];
  assign w_in_man = (w_in_exp == '0) ? '0 : i_fp[M-1:0];
  // Sign of x*x is sx XOR sx, which is always 0.
  assign w_sign   = r_sign ^ r_sign;

  ipsxe_floating_point_square_round_v1_0 #(
    .EXPONENT_SIZE (EXPONENT_SIZE),
    .MANTISSA_SIZE (MANTISSA_SIZE)
  ) u_round (
    .i_sign      (w_sign),
    .i_exp       (r_exp),
    .i_man       (r_man),
    .i_prod      (r_acc),
    .o_result    (w_result),
    .o_overflow  (w_ovf),
    .o_underflow (w_unf)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_sign       <= 1'b0;
      r_exp        <= '0;
      r_man        <= '0;
      r_mcand      <= '0;
      r_mplr       <= '0;
      r_acc        <= '0;
      r_rnd_result <= '0;
      r_rnd_ovf    <= 1'b0;
      r_rnd_unf    <= 1'b0;
      r_ready      <= 1'b1;
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
    end else if (i_aclken) begin
      // o_valid lasts one enabled cycle; while disabled it simply holds.
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_sign  <= i_fp[E+M];
            r_exp   <= w_in_exp;
            r_man   <= w_in_man;
            r_mcand <= {{MW{1'b0}}, 1'b1, w_in_man};
            r_mplr  <= {1'b1, w_in_man};
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          // LSB-first shift-add: add the shifted multiplicand for each set
          // multiplier bit.
          if (r_mplr[0])
            r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_ROUND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ROUND: begin
          r_rnd_result <= w_result;
          r_rnd_ovf    <= w_ovf;
          r_rnd_unf    <= w_unf;
          r_state      <= ST_DONE;
        end
        ST_DONE: begin
          r_result <= r_rnd_result;
          r_ovf    <= r_rnd_ovf;
          r_unf    <= r_rnd_unf;
          r_valid  <= 1'b1;
          r_ready  <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_valid     = r_valid;
  assign o_result    = r_result;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_ipsxe_floating_point_square_v1_0.sv
`default_nettype none
// ============================================================================
// Module  : tb_ipsxe_floating_point_square_v1_0
// Purpose : Self-checking bench for the single-precision squarer: directed
//           vectors, randomized operands against an arithmetic reference
//           model, busy/handshake, clock-enable stall and mid-op reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ipsxe_floating_point_square_v1_0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aclken;
  logic        valid;
  logic [31:0] fp;
  logic        ready;
  logic [31:0] result;
  logic        ovalid;
  logic        ovf;
  logic        unf;

  int n_checks = 0;
  int n_fail   = 0;

  ipsxe_floating_point_square_v1_0 #(
    .EXPONENT_SIZE (8),
    .MANTISSA_SIZE (23)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_aclken    (aclken),
    .i_valid     (valid),
    .i_fp        (fp),
    .o_ready     (ready),
    .o_result    (result),
    .o_valid     (ovalid),
    .o_overflow  (ovf),
    .o_underflow (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact square of the operand, rounded to nearest-even at 24 bits.
  function automatic void model(input logic [31:0] x, output logic [31:0] r,
                                output logic ov, output logic un);
    int e, lead, s, ex;
    longint unsigned m, p, q, rem, half;
    e = int'(x[30:23]);
    r = 32'h0; ov = 1'b0; un = 1'b0;
    if (e == 255) begin
      r = (x[22:0] != 23'd0) ? 32'h7FC00000 : 32'h7F800000;
    end else if (e != 0) begin
      m = {40'd0, 1'b1, x[22:0]};
      p = m * m;
      lead = 0;
      for (int i = 0; i < 64; i++) if (p[i]) lead = i;
      s    = lead - 23;
      q    = p >> s;
      rem  = p - (q << s);
      half = 64'd1 << (s - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      ex = 2 * (e - 127) + (lead - 46) + 127;
      if (q == (64'd1 << 24)) begin q = q >> 1; ex++; end
      if (ex >= 255) begin r = 32'h7F800000; ov = 1'b1; end
      else if (ex <= 0) un = 1'b1;
      else r = {1'b0, ex[7:0], q[22:0]};
    end
  endfunction

  // Issue one operand and wait (bounded) for o_valid. edges counts every
  // clock edge after the accepting one, including disabled ones.
  task automatic run_op(input logic [31:0] x, input bit spam, input int stall_at,
                        input int stall_len, output int edges, output bit got);
    int en_edges, stalled;
    bit saw_ready;
    check("ready_before_op", {31'd0, ready}, 32'd1);
    @(negedge clk);
    valid = 1'b1;
    fp    = x;
    @(posedge clk);
    #1;
    valid = spam;
    if (spam) fp = $urandom;
    edges = 0; en_edges = 0; stalled = 0; got = 1'b0; saw_ready = 1'b0;
    while (!got && edges < 200) begin
      @(negedge clk);
      if (stall_at >= 0 && en_edges == stall_at && stalled < stall_len) begin
        aclken = 1'b0;
        stalled++;
      end else begin
        aclken = 1'b1;
      end
      @(posedge clk);
      edges++;
      if (aclken) en_edges++;
      #1;
      if (ovalid) got = 1'b1;
      else if (ready) saw_ready = 1'b1;
    end
    aclken = 1'b1;
    valid  = 1'b0;
    check("ready_low_while_busy", {31'd0, saw_ready}, 32'd0);
    check("valid_seen", {31'd0, got}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] r;
    logic        ov;
    logic        un;
  } vec_t;

  vec_t vecs [9] = '{
    '{32'h40400000, 32'h41100000, 1'b0, 1'b0},
    '{32'h3F800001, 32'h3F800002, 1'b0, 1'b0},
    '{32'h3FC00000, 32'h40100000, 1'b0, 1'b0},
    '{32'h5F800000, 32'h7F800000, 1'b1, 1'b0},
    '{32'h1F800000, 32'h00000000, 1'b0, 1'b1},
    '{32'hFF800000, 32'h7F800000, 1'b0, 1'b0},
    '{32'h7FC00001, 32'h7FC00000, 1'b0, 1'b0},
    '{32'h80000000, 32'h00000000, 1'b0, 1'b0},
    '{32'h00000001, 32'h00000000, 1'b0, 1'b0}
  };

  initial begin
    int edges, extra;
    bit got;
    logic [31:0] x, er;
    logic eov, eun;

    rst_n = 1'b0; aclken = 1'b0; valid = 1'b0; fp = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_valid", {31'd0, ovalid}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_unf", {31'd0, unf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; aclken = 1'b1;

    // Directed vectors with known answers
    foreach (vecs[i]) begin
      run_op(vecs[i].x, 1'b0, -1, 0, edges, got);
      check($sformatf("dir%0d_latency", i), 32'(edges), 32'd26);
      check($sformatf("dir%0d_result", i), result, vecs[i].r);
      check($sformatf("dir%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ov});
      check($sformatf("dir%0d_unf", i), {31'd0, unf}, {31'd0, vecs[i].un});
      @(posedge clk); #1;
      check($sformatf("dir%0d_pulse", i), {31'd0, ovalid}, 32'd0);
    end

    // Randomized operands, biased toward the overflow/underflow boundaries
    for (int i = 0; i < 30; i++) begin
      x = $urandom;
      if (i % 3 == 0) x[30:23] = 8'($urandom_range(60, 68));
      else if (i % 3 == 1) x[30:23] = 8'($urandom_range(186, 194));
      model(x, er, eov, eun);
      run_op(x, 1'b0, -1, 0, edges, got);
      check($sformatf("rnd%0d_latency", i), 32'(edges), 32'd26);
      check($sformatf("rnd%0d_result x=%h", i, x), result, er);
      check($sformatf("rnd%0d_ovf", i), {31'd0, ovf}, {31'd0, eov});
      check($sformatf("rnd%0d_unf", i), {31'd0, unf}, {31'd0, eun});
    end

    // i_valid held high with fresh operands while busy: ignored
    run_op(32'h40400000, 1'b1, -1, 0, edges, got);
    check("spam_result", result, 32'h41100000);
    check("spam_latency", 32'(edges), 32'd26);
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (ovalid) extra++; end
    check("spam_extra_valid", 32'(extra), 32'd0);

    // Clock enable low for 5 cycles during MUL stretches latency by 5
    run_op(32'h3FC00000, 1'b0, 5, 5, edges, got);
    check("stall_latency", 32'(edges), 32'd31);
    check("stall_result", result, 32'h40100000);
    // o_valid stretches while the enable is low
    @(negedge clk); aclken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stretch_valid", {31'd0, ovalid}, 32'd1);
    check("stretch_result", result, 32'h40100000);
    @(negedge clk); aclken = 1'b1;
    @(posedge clk); #1;
    check("stretch_end", {31'd0, ovalid}, 32'd0);

    // Reset at MUL cycle 10 aborts the operation
    @(negedge clk); valid = 1'b1; fp = 32'h40400000;
    @(posedge clk); #1; valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_valid", {31'd0, ovalid}, 32'd0);
    check("midrst_result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (ovalid) extra++; end
    check("midrst_stale_valid", 32'(extra), 32'd0);

    // Block is usable again after the abort
    run_op(32'h40400000, 1'b0, -1, 0, edges, got);
    check("post_rst_result", result, 32'h41100000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ipsxe_floating_point_square_v1_0.md
IPSXE_FLOATING_POINT_SQUARE_V1_0 -- requirements
Module: ipsxe_floating_point_square_v1_0

Interface
REQ-001 The block SHALL have parameter EXPONENT_SIZE, default 8, giving the exponent field width.
REQ-002 The block SHALL have parameter MANTISSA_SIZE, default 23, giving the stored mantissa width.
REQ-003 i_clk  input  1  sole clock; one clock, all state on its rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous and active-low.
REQ-005 i_aclken  input  1  clock enable; low freezes all state and outputs.
REQ-006 i_valid  input  1  operand valid; accepted only when o_ready=1 and i_aclken=1.
REQ-007 i_fp  input  1+EXPONENT_SIZE+MANTISSA_SIZE  IEEE-754 operand x.
REQ-008 o_ready  output  1  high when the block can accept an operand.
REQ-009 o_result  output  1+EXPONENT_SIZE+MANTISSA_SIZE  x*x.
REQ-010 o_valid  output  1  one-cycle pulse qualifying o_result and the flags.
REQ-011 o_overflow  output  1  result saturated to +Inf from finite input.
REQ-012 o_underflow  output  1  result flushed to +0 from nonzero finite input.

Function
REQ-013 The block SHALL be an iterative shift-add squarer with FSM states IDLE, MUL, ROUND, DONE.
REQ-014 IDLE: o_ready=1; on accept, latch operand, clear the product accumulator, go to MUL.
REQ-015 MUL: process one multiplier bit per enabled cycle for exactly MANTISSA_SIZE+1 cycles using a counter, then go to ROUND.
REQ-016 ROUND: normalise and round in one cycle, then go to DONE.
REQ-017 DONE: o_valid=1 for exactly one enabled cycle, o_result and flags are held until the next DONE, then the FSM returns to IDLE.
REQ-018 Latency SHALL be fixed at MANTISSA_SIZE+3 enabled cycles from the accepting edge to the edge raising o_valid (26 for single precision), including special cases.
REQ-019 o_ready SHALL be low in MUL, ROUND and DONE, and i_valid SHALL be ignored there without being queued.
REQ-020 Denormal inputs (exponent field 0) SHALL be flushed to zero before use.
REQ-021 Mantissa product: {1,man} x {1,man} SHALL be computed as a 2*(MANTISSA_SIZE+1)-bit value; if its MSB is set, it SHALL be shifted right by 1 and the exponent incremented.
REQ-022 Exponent SHALL be computed in signed EXPONENT_SIZE+2 bits as 2*e - BIAS + norm, with BIAS = 2^(EXPONENT_SIZE-1)-1.
REQ-023 Rounding SHALL be round-to-nearest-even using guard and sticky bits; a mantissa carry-out SHALL increment the exponent.
REQ-024 If the rounded exponent is >= 2^EXPONENT_SIZE-1, the result SHALL be +Inf with o_overflow=1.
REQ-025 If the rounded exponent is <= 0, the result SHALL be +0 with o_underflow=1.
REQ-026 Result sign SHALL always be 0.
REQ-027 Specials: NaN input SHALL give qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0); Inf of either sign SHALL give +Inf; zero or denormal SHALL give +0; no flags are raised for specials.
REQ-028 When i_aclken=0, FSM, counter, accumulator and outputs SHALL hold, and an o_valid pulse SHALL stretch until the next enabled edge.

Reset
REQ-029 On an i_clk edge with i_rst_n=0, regardless of i_aclken: FSM=IDLE, counter=0, accumulator=0, o_ready=1, o_valid=0, o_overflow=0, o_underflow=0, o_result=0.
REQ-030 Reset mid-operation SHALL abort the operation, and no o_valid for the aborted operand SHALL ever appear.

Structure
REQ-031 The shared package ipsxe_floating_point_pkg SHALL hold the FSM state encodings and the BIAS/exponent-all-ones constant functions.
REQ-032 Normalisation, RNE rounding, overflow/underflow and special-case result selection SHALL be a combinational sub-module ipsxe_floating_point_square_round_v1_0.
REQ-033 The top level SHALL contain only the FSM, the counter, the shift-add datapath and the output registers.

Verification
REQ-034 0x40400000 (3.0) -> 0x41100000 (9.0), o_valid 26 cycles after accept, no flags.
REQ-035 0x3F800001 -> 0x3F800002 (RNE discards 2^-46); 0x3FC00000 (1.5) -> 0x40100000 (2.25).
REQ-036 0x5F800000 (2^64) -> 0x7F800000 with o_overflow=1; 0x1F800000 (2^-64) -> 0x00000000 with o_underflow=1.
REQ-037 0xFF800000 -> 0x7F800000; 0x7FC00001 -> 0x7FC00000; 0x80000000 -> 0x00000000; 0x00000001 -> 0x00000000; no flags in any of these cases.
REQ-038 i_valid held high with a new operand while busy -> ignored, o_ready low, exactly one o_valid.
REQ-039 Deassert i_aclken for 5 cycles during MUL -> latency extends by 5 cycles with the correct result.
REQ-040 Reset at MUL cycle 10 -> o_ready=1 next cycle and no stale o_valid.
